// File: rtl/breakout_pkg.sv
// Shared constants for the breakout ball datapath: direction codes, FSM
// state encoding and screen/ball/paddle geometry.
package breakout_pkg;

  // bit0 = west, bit1 = north
  localparam logic [1:0] DIR_NE = 2'b10;
  localparam logic [1:0] DIR_SE = 2'b00;
  localparam logic [1:0] DIR_SW = 2'b01;
  localparam logic [1:0] DIR_NW = 2'b11;

  localparam logic [1:0] ST_SERVE     = 2'd0;
  localparam logic [1:0] ST_PLAY      = 2'd1;
  localparam logic [1:0] ST_LOST      = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 32;
  localparam int PADDLE_Y    = 440;
  localparam int PADDLE_H    = 8;
  localparam int PADDLE_W    = 64;
  localparam int WALL_MARGIN = 3;

endpackage

// File: rtl/ball_collision_detect.sv
// Combinational collision classifier: walls, bricks, paddle and bottom miss
// for the current ball position and direction.
module ball_collision_detect
  import breakout_pkg::*;
(
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] paddleX,
  input  logic [1:0] direction,
  input  logic       brickH,
  input  logic       brickV,
  output logic       flipX,
  output logic       flipY,
  output logic       paddleHit,
  output logic       paddleWest,
  output logic       miss
);

  // Widened to 11 bits so ball/paddle far edges never wrap near the screen edge.
  logic [10:0] x, y, px, x_far, y_far;

  assign x     = {1'b0, ballX};
  assign y     = {1'b0, ballY};
  assign px    = {1'b0, paddleX};
  assign x_far = x + 11'(BALL_SIZE);
  assign y_far = y + 11'(BALL_SIZE);

  assign flipX = (direction[0] && (x <= 11'(WALL_MARGIN)))
              || (!direction[0] && (x_far >= 11'(SCREEN_W - WALL_MARGIN)))
              || brickH;

  assign flipY = (direction[1] && (y <= 11'(WALL_MARGIN))) || brickV;

  assign paddleHit = !direction[1]
                  && (y_far >= 11'(PADDLE_Y))
                  && (y_far <  11'(PADDLE_Y + PADDLE_H))
                  && (x_far >  px)
                  && (x     <  px + 11'(PADDLE_W));

  assign paddleWest = (x + 11'(BALL_SIZE / 2)) < (px + 11'(PADDLE_W / 2));

  assign miss = !direction[1] && (y_far >= 11'(SCREEN_H)) && !paddleHit;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball sequencer: owns the direction, issues position-update and
// respawn strobes, and runs the serve / play / lost / game-over flow.
module ball_motion_ctrl
  import breakout_pkg::*;
#(
  parameter int SPEED_DIV      = 1,
  parameter int RESPAWN_FRAMES = 60,
  parameter int START_LIVES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameTick,
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] paddleX,
  input  logic       brickHitH,
  input  logic       brickHitV,
  input  logic       launch,
  output logic [1:0] direction,
  output logic       ballPosUpdate,
  output logic       ballRespawn,
  output logic [1:0] lives,
  output logic       gameOver
);

  localparam int RW = $clog2(RESPAWN_FRAMES + 1);

  logic [1:0]    state;
  logic [3:0]    frame_cnt;
  logic [RW-1:0] respawn_cnt;
  logic          brick_h, brick_v;
  logic          serve_armed;
  logic          flip_x, flip_y, paddle_hit, paddle_west, miss;
  logic [1:0]    next_dir;

  // A pulse coincident with the frame tick joins that tick's evaluation.
  ball_collision_detect u_collide (
    .ballX      (ballX),
    .ballY      (ballY),
    .paddleX    (paddleX),
    .direction  (direction),
    .brickH     (brick_h | brickHitH),
    .brickV     (brick_v | brickHitV),
    .flipX      (flip_x),
    .flipY      (flip_y),
    .paddleHit  (paddle_hit),
    .paddleWest (paddle_west),
    .miss       (miss)
  );

  always_comb begin
    // NOTE: default first so every path assigns next_dir and no latch is inferred.
    next_dir = direction;
    if (paddle_hit) next_dir = {1'b1, paddle_west};
    else            next_dir = {direction[1] ^ flip_y, direction[0] ^ flip_x};
  end

  // NOTE: non-blocking assignments throughout so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_SERVE;
      direction     <= DIR_NE;
      ballPosUpdate <= 1'b0;
      ballRespawn   <= 1'b0;
      lives         <= 2'(START_LIVES);
      gameOver      <= 1'b0;
      frame_cnt     <= '0;
      respawn_cnt   <= '0;
      brick_h       <= 1'b0;
      brick_v       <= 1'b0;
      serve_armed   <= 1'b1;
    end else begin
      ballPosUpdate <= 1'b0;
      ballRespawn   <= 1'b0;
      if (!launch) serve_armed <= 1'b1;

      case (state)
        ST_SERVE: begin
          brick_h <= 1'b0;
          brick_v <= 1'b0;
          if (launch && serve_armed) begin
            direction <= DIR_NE;
            frame_cnt <= '0;
            state     <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (frameTick) begin
            brick_h <= 1'b0;
            brick_v <= 1'b0;
            if (miss) begin
              lives       <= lives - 2'd1;
              respawn_cnt <= '0;
              if (lives == 2'd1) begin
                state    <= ST_GAME_OVER;
                gameOver <= 1'b1;
              end else begin
                state <= ST_LOST;
              end
            end else begin
              direction <= next_dir;
              if (frame_cnt == 4'(SPEED_DIV - 1)) begin
                frame_cnt     <= '0;
                ballPosUpdate <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 4'd1;
              end
            end
          end else begin
            brick_h <= brick_h | brickHitH;
            brick_v <= brick_v | brickHitV;
          end
        end

        ST_LOST: begin
          if (frameTick) begin
            if (respawn_cnt == RW'(RESPAWN_FRAMES - 1)) begin
              respawn_cnt <= '0;
              ballRespawn <= 1'b1;
              state       <= ST_SERVE;
            end else begin
              respawn_cnt <= respawn_cnt + RW'(1);
            end
          end
        end

        ST_GAME_OVER: begin
          // Restart needs a fresh press before the next serve.
          if (launch) begin
            lives       <= 2'(START_LIVES);
            ballRespawn <= 1'b1;
            gameOver    <= 1'b0;
            serve_armed <= 1'b0;
            state       <= ST_SERVE;
          end
        end

        default: state <= ST_SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: reflections, paddle, miss/respawn,
// game-over restart, frame divider and mid-strobe reset.
module tb_ball_motion_ctrl;
  import breakout_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       frameTick, brickHitH, brickHitV, launch;
  logic [9:0] ballX, ballY, paddleX;

  logic [1:0] direction, direction3;
  logic       ballPosUpdate, ballPosUpdate3;
  logic       ballRespawn, ballRespawn3;
  logic [1:0] lives, lives3;
  logic       gameOver, gameOver3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl #(.SPEED_DIV(1)) dut (
    .clk(clk), .reset(reset), .frameTick(frameTick), .ballX(ballX), .ballY(ballY),
    .paddleX(paddleX), .brickHitH(brickHitH), .brickHitV(brickHitV), .launch(launch),
    .direction(direction), .ballPosUpdate(ballPosUpdate), .ballRespawn(ballRespawn),
    .lives(lives), .gameOver(gameOver)
  );

  ball_motion_ctrl #(.SPEED_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .frameTick(frameTick), .ballX(ballX), .ballY(ballY),
    .paddleX(paddleX), .brickHitH(brickHitH), .brickHitV(brickHitV), .launch(launch),
    .direction(direction3), .ballPosUpdate(ballPosUpdate3), .ballRespawn(ballRespawn3),
    .lives(lives3), .gameOver(gameOver3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame tick in cycle T with optional brick pulses; returns mid-cycle T+1.
  task automatic pulse_tick(input logic hh, input logic hv);
    @(negedge clk);
    frameTick = 1'b1; brickHitH = hh; brickHitV = hv;
    @(negedge clk);
    frameTick = 1'b0; brickHitH = 1'b0; brickHitV = 1'b0;
  endtask

  task automatic press_launch();
    @(negedge clk); launch = 1'b1;
    @(negedge clk); launch = 1'b0;
  endtask

  task automatic tick_at(input logic [9:0] x, input logic [9:0] y);
    ballX = x; ballY = y;
    pulse_tick(1'b0, 1'b0);
  endtask

  // From NE in PLAY: bounce off the top to SE, then drop past the paddle.
  task automatic do_miss(input logic [1:0] exp_lives);
    paddleX = 10'd500;
    tick_at(10'd300, 10'd2);
    check("miss_prep_dir", direction, DIR_SE);
    tick_at(10'd300, 10'd450);
    check("miss_lives", lives, exp_lives);
    check("miss_no_upd", ballPosUpdate, 0);
  endtask

  task automatic do_respawn();
    int noise = 0;
    for (int i = 0; i < 60; i++) begin
      pulse_tick(1'b0, 1'b0);
      if (i < 59) begin
        if (ballRespawn || ballPosUpdate) noise++;
      end else begin
        check("respawn_pulse", ballRespawn, 1);
      end
    end
    check("lost_quiet", noise, 0);
    check("lost_no_upd", ballPosUpdate, 0);
    @(negedge clk);
    check("respawn_one_cycle", ballRespawn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frameTick = 1'b0; brickHitH = 1'b0; brickHitV = 1'b0; launch = 1'b0;
    ballX = 10'd300; ballY = 10'd200; paddleX = 10'd0;
    repeat (2) @(negedge clk);
    check("rst_dir", direction, DIR_NE);
    check("rst_upd", ballPosUpdate, 0);
    check("rst_respawn", ballRespawn, 0);
    check("rst_lives", lives, 3);
    check("rst_gameover", gameOver, 0);
    reset = 1'b0;

    // SERVE holds updates off until launch.
    pulse_tick(1'b0, 1'b0);
    check("serve_no_upd", ballPosUpdate, 0);
    press_launch();
    check("serve_dir", direction, DIR_NE);

    // East wall then west wall.
    tick_at(10'd610, 10'd200);
    check("east_wall_dir", direction, DIR_NW);
    check("east_wall_upd", ballPosUpdate, 1);
    tick_at(10'd2, 10'd200);
    check("west_wall_dir", direction, DIR_NE);
    check("west_wall_upd", ballPosUpdate, 1);
    @(negedge clk);
    check("upd_one_cycle", ballPosUpdate, 0);

    // Corner plus coincident brick side hit: x flips once.
    tick_at(10'd610, 10'd200);
    ballX = 10'd2; ballY = 10'd2;
    pulse_tick(1'b1, 1'b0);
    check("corner_dir", direction, DIR_SE);

    // Sticky brick-V flag from an earlier cycle, consumed by the next tick.
    ballX = 10'd300; ballY = 10'd200;
    @(negedge clk); brickHitV = 1'b1;
    @(negedge clk); brickHitV = 1'b0;
    repeat (3) @(negedge clk);
    pulse_tick(1'b0, 1'b0);
    check("brick_v_sticky", direction, DIR_NE);
    pulse_tick(1'b0, 1'b0);
    check("brick_flag_cleared", direction, DIR_NE);

    // Paddle, left half -> NW.
    tick_at(10'd300, 10'd2);
    paddleX = 10'd290;
    tick_at(10'd300, 10'd410);
    check("paddle_left", direction, DIR_NW);

    // Paddle, right half -> NE, overriding a coincident brick side hit.
    tick_at(10'd2, 10'd2);
    check("corner_nw", direction, DIR_SE);
    paddleX = 10'd270; ballX = 10'd300; ballY = 10'd410;
    pulse_tick(1'b1, 1'b0);
    check("paddle_right", direction, DIR_NE);

    // Miss, respawn, serve.
    do_miss(2'd2);
    check("lost_gameover", gameOver, 0);
    do_respawn();
    pulse_tick(1'b0, 1'b0);
    check("serve_after_lost", ballPosUpdate, 0);
    press_launch();
    check("serve_dir_lost", direction, DIR_NE);

    do_miss(2'd1);
    do_respawn();
    press_launch();
    do_miss(2'd0);
    check("gameover_set", gameOver, 1);
    pulse_tick(1'b0, 1'b0);
    check("gameover_no_upd", ballPosUpdate, 0);

    // Restart with launch held: respawn but no serve until re-pressed.
    @(negedge clk); launch = 1'b1;
    @(negedge clk);
    check("restart_respawn", ballRespawn, 1);
    check("restart_lives", lives, 3);
    check("restart_gameover", gameOver, 0);
    @(negedge clk);
    check("restart_respawn_once", ballRespawn, 0);
    ballY = 10'd200;
    pulse_tick(1'b0, 1'b0);
    check("held_launch_no_serve", ballPosUpdate, 0);
    launch = 1'b0;
    press_launch();
    pulse_tick(1'b0, 1'b0);
    check("repress_serves", ballPosUpdate, 1);

    // Divider of 3.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    ballX = 10'd300; ballY = 10'd200;
    press_launch();
    for (int i = 1; i <= 6; i++) begin
      pulse_tick(1'b0, 1'b0);
      check($sformatf("div3_tick%0d", i), ballPosUpdate3, (i % 3 == 0) ? 1 : 0);
    end

    // Reset coincident with a live strobe.
    tick_at(10'd610, 10'd200);
    check("pre_rst_dir", direction, DIR_NW);
    check("pre_rst_upd", ballPosUpdate, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_dir", direction, DIR_NE);
    check("mid_rst_upd", ballPosUpdate, 0);
    check("mid_rst_lives", lives, 3);
    check("mid_rst_gameover", gameOver, 0);
    @(negedge clk); reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
